// File: rtl/sprite_compositor_if.sv
// Pixel stream bus for sprite_compositor: coordinate input side and registered RGB output side.
interface sprite_compositor_if #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 8
);
    logic               pix_valid;
    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic [COLOR_W-1:0] Red;
    logic [COLOR_W-1:0] Green;
    logic [COLOR_W-1:0] Blue;
    logic               pix_valid_out;

    modport master (
        output pix_valid, DrawX, DrawY,
        input  Red, Green, Blue, pix_valid_out
    );

    modport slave (
        input  pix_valid, DrawX, DrawY,
        output Red, Green, Blue, pix_valid_out
    );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: frame-shadowed rectangle/circle hit test, then lowest-index colour select.
// Optional collision tracking is built when SPRITE_COMPOSITOR_COLLISION_EN is defined.
module sprite_compositor #(
    parameter int NUM_OBJ = 4,
    parameter int COORD_W = 10,
    parameter int COLOR_W = 8
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_start,
    sprite_compositor_if.slave             pix,
    input  logic [NUM_OBJ*COORD_W-1:0]     ObjX,
    input  logic [NUM_OBJ*COORD_W-1:0]     ObjY,
    input  logic [NUM_OBJ*COORD_W-1:0]     ObjHalfW,
    input  logic [NUM_OBJ*COORD_W-1:0]     ObjHalfH,
    input  logic [NUM_OBJ-1:0]             ObjShape,
    input  logic [NUM_OBJ-1:0]             ObjEn,
    input  logic [NUM_OBJ*3*COLOR_W-1:0]   ObjColor,
    input  logic [3*COLOR_W-1:0]           BgColor,
    output logic [NUM_OBJ-1:0]             coll_status
);
    localparam int DW  = COORD_W + 2;
    localparam int SQW = 2*COORD_W + 2;
    localparam int CW  = 3*COLOR_W;

    logic [NUM_OBJ*COORD_W-1:0] shX, shY, shHalfW, shHalfH;
    logic [NUM_OBJ-1:0]         shShape, shEn;
    logic [NUM_OBJ*CW-1:0]      shColor;

    logic [NUM_OBJ*COORD_W-1:0] curX, curY, curHalfW, curHalfH;
    logic [NUM_OBJ-1:0]         curShape, curEn;
    logic [NUM_OBJ*CW-1:0]      curColor;

    logic [NUM_OBJ-1:0]         hitComb;
    logic [CW-1:0]              firstColor;

    logic                       s1Valid;
    logic [NUM_OBJ-1:0]         s1Hit;
    logic [CW-1:0]              s1Color;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            shX     <= '0;
            shY     <= '0;
            shHalfW <= '0;
            shHalfH <= '0;
            shShape <= '0;
            shEn    <= '0;
            shColor <= '0;
        end else if (frame_start) begin
            shX     <= ObjX;
            shY     <= ObjY;
            shHalfW <= ObjHalfW;
            shHalfH <= ObjHalfH;
            shShape <= ObjShape;
            shEn    <= ObjEn;
            shColor <= ObjColor;
        end
    end

    // A pixel arriving with frame_start already belongs to the new frame.
    always_comb begin
        curX     = frame_start ? ObjX     : shX;
        curY     = frame_start ? ObjY     : shY;
        curHalfW = frame_start ? ObjHalfW : shHalfW;
        curHalfH = frame_start ? ObjHalfH : shHalfH;
        curShape = frame_start ? ObjShape : shShape;
        curEn    = frame_start ? ObjEn    : shEn;
        curColor = frame_start ? ObjColor : shColor;
    end

    always_comb begin
        logic signed [DW-1:0] dx, dy;
        logic [DW-1:0]        adx, ady;
        logic [SQW-1:0]       dist2, rad2;
        logic                 rectHit;
        hitComb = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            dx      = $signed({2'b00, pix.DrawX}) - $signed({2'b00, curX[i*COORD_W +: COORD_W]});
            dy      = $signed({2'b00, pix.DrawY}) - $signed({2'b00, curY[i*COORD_W +: COORD_W]});
            adx     = dx[DW-1] ? DW'(-dx) : DW'(dx);
            ady     = dy[DW-1] ? DW'(-dy) : DW'(dy);
            dist2   = SQW'(adx) * SQW'(adx) + SQW'(ady) * SQW'(ady);
            rad2    = SQW'(curHalfW[i*COORD_W +: COORD_W]) * SQW'(curHalfW[i*COORD_W +: COORD_W]);
            rectHit = (adx <= DW'(curHalfW[i*COORD_W +: COORD_W])) &&
                      (ady <= DW'(curHalfH[i*COORD_W +: COORD_W]));
            hitComb[i] = curEn[i] && (curShape[i] ? (dist2 <= rad2) : rectHit);
        end
    end

    // The winning colour is captured alongside the hit vector so a pixel in flight
    // across frame_start keeps the colour of the frame it was sampled in.
    always_comb begin
        int unsigned idx;
        firstColor = '0;
        for (int unsigned k = 0; k < NUM_OBJ; k++) begin
            idx = NUM_OBJ - 1 - k;
            if (hitComb[idx]) firstColor = curColor[idx*CW +: CW];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1Valid <= 1'b0;
            s1Hit   <= '0;
            s1Color <= '0;
        end else begin
            s1Valid <= pix.pix_valid;
            s1Hit   <= hitComb;
            s1Color <= firstColor;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix.pix_valid_out <= 1'b0;
            {pix.Red, pix.Green, pix.Blue} <= '0;
        end else begin
            pix.pix_valid_out <= s1Valid;
            if (!s1Valid)
                {pix.Red, pix.Green, pix.Blue} <= '0;
            else if (|s1Hit)
                {pix.Red, pix.Green, pix.Blue} <= s1Color;
            else
                {pix.Red, pix.Green, pix.Blue} <= BgColor;
        end
    end

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
    logic [NUM_OBJ-1:0] collWork, collReg, pixColl;

    // Clearing the lowest set bit leaves a nonzero vector only when two or more objects hit.
    always_comb begin
        pixColl = '0;
        if (s1Valid && |(s1Hit & (s1Hit - NUM_OBJ'(1)))) pixColl = s1Hit;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            collWork <= '0;
            collReg  <= '0;
        end else if (frame_start) begin
            collReg  <= collWork | pixColl;
            collWork <= '0;
        end else begin
            collWork <= collWork | pixColl;
        end
    end

    assign coll_status = collReg;
`else
    assign coll_status = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: stimulus pushes expected pixels, a negedge monitor pops and compares.
module tb_sprite_compositor;
    localparam int NUM_OBJ = 4;
    localparam int COORD_W = 10;
    localparam int COLOR_W = 8;
    localparam int CW      = 3*COLOR_W;

    localparam logic [CW-1:0] RED    = 24'hFF0000;
    localparam logic [CW-1:0] GREEN  = 24'h00FF00;
    localparam logic [CW-1:0] BLUE   = 24'h0000FF;
    localparam logic [CW-1:0] YELLOW = 24'hFFFF00;
    localparam logic [CW-1:0] BG     = 24'h202020;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frameStart = 1'b0;
    logic [NUM_OBJ*COORD_W-1:0] objX = '0, objY = '0, objHalfW = '0, objHalfH = '0;
    logic [NUM_OBJ-1:0]         objShape = '0, objEn = '0;
    logic [NUM_OBJ*CW-1:0]      objColor = '0;
    logic [CW-1:0]              bgColor = BG;
    logic [NUM_OBJ-1:0]         collStatus;

    sprite_compositor_if #(.COORD_W(COORD_W), .COLOR_W(COLOR_W)) pixBus ();

    sprite_compositor #(.NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .COLOR_W(COLOR_W)) dut (
        .Clk(clk), .Reset(rst), .frame_start(frameStart), .pix(pixBus),
        .ObjX(objX), .ObjY(objY), .ObjHalfW(objHalfW), .ObjHalfH(objHalfH),
        .ObjShape(objShape), .ObjEn(objEn), .ObjColor(objColor), .BgColor(bgColor),
        .coll_status(collStatus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic monOn = 1'b0;
    logic [CW-1:0] expQ[$];
    logic [NUM_OBJ-1:0] expColl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            if (pixBus.pix_valid_out) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pixel: got %h, expected no output", {pixBus.Red, pixBus.Green, pixBus.Blue});
                end else begin
                    check("pixel_rgb", 32'({pixBus.Red, pixBus.Green, pixBus.Blue}), 32'(expQ.pop_front()));
                end
            end else begin
                check("idle_rgb_zero", 32'({pixBus.Red, pixBus.Green, pixBus.Blue}), 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drivePix(input int x, input int y, input bit push, input logic [CW-1:0] exp);
        pixBus.pix_valid = 1'b1;
        pixBus.DrawX = COORD_W'(x);
        pixBus.DrawY = COORD_W'(y);
        if (push) expQ.push_back(exp);
        tick();
        pixBus.pix_valid = 1'b0;
    endtask

    task automatic pulseFrame();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    task automatic setObj(input int i, input int x, input int y, input int hw, input int hh,
                          input bit shape, input bit en, input logic [CW-1:0] col);
        objX[i*COORD_W +: COORD_W]     = COORD_W'(x);
        objY[i*COORD_W +: COORD_W]     = COORD_W'(y);
        objHalfW[i*COORD_W +: COORD_W] = COORD_W'(hw);
        objHalfH[i*COORD_W +: COORD_W] = COORD_W'(hh);
        objShape[i] = shape;
        objEn[i]    = en;
        objColor[i*CW +: CW] = col;
    endtask

    initial begin
        pixBus.pix_valid = 1'b0;
        pixBus.DrawX = '0;
        pixBus.DrawY = '0;
        repeat (2) tick();
        @(negedge clk);
        check("reset_valid_out", 32'(pixBus.pix_valid_out), 32'h0);
        check("reset_rgb", 32'({pixBus.Red, pixBus.Green, pixBus.Blue}), 32'h0);
        check("reset_coll", 32'(collStatus), 32'h0);
        rst = 1'b0;
        monOn = 1'b1;
        tick();

        // Rectangle edges
        setObj(0, 100, 100, 10, 10, 1'b0, 1'b1, RED);
        pulseFrame();
        drivePix(110, 90, 1, RED);
        drivePix(111, 90, 1, BG);
        drivePix(90, 110, 1, RED);
        drivePix(89, 100, 1, BG);

        // Circle boundary
        setObj(1, 200, 200, 5, 5, 1'b1, 1'b1, BLUE);
        pulseFrame();
        drivePix(203, 204, 1, BLUE);
        drivePix(204, 204, 1, BG);
        drivePix(195, 200, 1, BLUE);
        drivePix(200, 206, 1, BG);

        // No wrap near coordinate 0
        setObj(0, 3, 3, 5, 5, 1'b0, 1'b1, RED);
        pulseFrame();
        drivePix(1020, 3, 1, BG);
        drivePix(0, 0, 1, RED);
        drivePix(8, 8, 1, RED);
        drivePix(9, 3, 1, BG);
        drivePix(3, 1020, 1, BG);

        // Mid-frame change is ignored until frame_start
        setObj(0, 500, 3, 5, 5, 1'b0, 1'b1, RED);
        drivePix(0, 0, 1, RED);
        pulseFrame();
        drivePix(0, 0, 1, BG);
        drivePix(500, 3, 1, RED);

        // In-flight pixel keeps old frame; coincident pixel uses new frame
        setObj(0, 3, 3, 5, 5, 1'b0, 1'b1, YELLOW);
        drivePix(500, 3, 1, RED);
        frameStart = 1'b1;
        drivePix(0, 0, 1, YELLOW);
        frameStart = 1'b0;
        drivePix(500, 3, 1, BG);

        // Collision: obj0 and obj2 overlap, obj3 overlaps but is disabled
        setObj(0, 50, 50, 5, 5, 1'b0, 1'b1, RED);
        setObj(1, 200, 200, 5, 5, 1'b1, 1'b0, BLUE);
        setObj(2, 50, 50, 3, 3, 1'b0, 1'b1, GREEN);
        setObj(3, 50, 50, 9, 9, 1'b0, 1'b0, BLUE);
        pulseFrame();
        @(negedge clk);
        check("coll_prev_frame", 32'(collStatus), 32'h0);
        tick();
        drivePix(50, 50, 1, RED);
        drivePix(54, 50, 1, RED);
        pulseFrame();
`ifdef SPRITE_COMPOSITOR_COLLISION_EN
        expColl = 4'b0101;
`else
        expColl = 4'b0000;
`endif
        @(negedge clk);
        check("coll_overlap", 32'(collStatus), 32'(expColl));
        tick();
        drivePix(60, 60, 1, BG);
        pulseFrame();
        @(negedge clk);
        check("coll_cleared", 32'(collStatus), 32'h0);
        tick();

        // Reset mid-stream with pix_valid held high
        drivePix(50, 50, 1, RED);
        drivePix(50, 50, 0, BG);
        pixBus.pix_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expQ.push_back(BG);
        @(negedge clk);
        check("rst_valid_out_1", 32'(pixBus.pix_valid_out), 32'h0);
        check("rst_rgb_1", 32'({pixBus.Red, pixBus.Green, pixBus.Blue}), 32'h0);
        check("rst_coll", 32'(collStatus), 32'h0);
        @(posedge clk);
        #1;
        expQ.push_back(BG);
        @(negedge clk);
        check("rst_valid_out_2", 32'(pixBus.pix_valid_out), 32'h0);
        check("rst_rgb_2", 32'({pixBus.Red, pixBus.Green, pixBus.Blue}), 32'h0);
        @(posedge clk);
        #1;
        pixBus.pix_valid = 1'b0;
        @(negedge clk);
        check("rst_valid_out_3", 32'(pixBus.pix_valid_out), 32'h1);

        repeat (5) tick();
        check("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
